// File: rtl/inreg.sv
// inreg: 64-bit input capture register read by the CPU one nibble at a time.
// Optional double buffering (pending word + FULL_PEND state) with INREG_DOUBLE_BUF_EN.
module inreg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        rd,
  output logic [3:0]  q,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready
);

  typedef enum logic [1:0] {EMPTY, FULL, FULL_PEND} state_t;

  state_t      state;
  logic [63:0] snap;
  logic [3:0]  cnt;
  logic        ovf;
`ifdef INREG_DOUBLE_BUF_EN
  logic [63:0] pend_data;
`endif

  logic       is_full;
  logic       is_pend;
  logic       release_rd;
  logic       read_cnt;
  logic       drop;
  logic       in_window;
  logic [3:0] nib_idx;
  logic [3:0] rdata;

  // Read decode; nibble k lives at address 10+4k, so the index is (addr-10)/4.
  always_comb begin
    is_full    = (state != EMPTY);
`ifdef INREG_DOUBLE_BUF_EN
    is_pend    = (state == FULL_PEND);
`else
    is_pend    = 1'b0;
`endif
    release_rd = rd && (addr == 16'd70) && is_full;
    read_cnt   = rd && (addr == 16'd7);
`ifdef INREG_DOUBLE_BUF_EN
    drop       = in_valid && (state == FULL_PEND) && !release_rd;
`else
    drop       = in_valid && (state == FULL) && !release_rd;
`endif
    in_window  = (addr >= 16'd10) && (addr <= 16'd70) && (addr[1:0] == 2'b10);
    nib_idx    = 4'((addr[5:0] - 6'd10) >> 2);
    rdata      = 4'h0;
    if (addr == 16'd6)
      rdata = {1'b0, is_pend, ovf, is_full};
    else if (addr == 16'd7)
      rdata = cnt;
    else if (in_window)
      rdata = snap[{nib_idx, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      snap      <= 64'h0;
      cnt       <= 4'h0;
      ovf       <= 1'b0;
      q         <= 4'h0;
      in_ready  <= 1'b0;
`ifdef INREG_DOUBLE_BUF_EN
      pend_data <= 64'h0;
`endif
    end else begin
      if (rd)
        q <= rdata;

      // A counter read clears first; a drop in the same cycle then counts as one.
      if (read_cnt) begin
        cnt <= {3'b000, drop};
        ovf <= drop;
      end else if (drop) begin
        if (cnt != 4'hF)
          cnt <= cnt + 4'h1;
        ovf <= 1'b1;
      end

      case (state)
        EMPTY: begin
          if (in_valid) begin
            snap  <= in_data;
            state <= FULL;
`ifdef INREG_DOUBLE_BUF_EN
            in_ready <= 1'b1;
`else
            in_ready <= 1'b0;
`endif
          end else begin
            in_ready <= 1'b1;
          end
        end
        FULL: begin
`ifdef INREG_DOUBLE_BUF_EN
          if (in_valid && release_rd) begin
            snap     <= in_data;
            in_ready <= 1'b1;
          end else if (in_valid) begin
            pend_data <= in_data;
            state     <= FULL_PEND;
            in_ready  <= 1'b0;
          end else if (release_rd) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
          end else begin
            in_ready <= 1'b1;
          end
`else
          if (release_rd && in_valid) begin
            snap     <= in_data;
            in_ready <= 1'b0;
          end else if (release_rd) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
          end else begin
            in_ready <= 1'b0;
          end
`endif
        end
`ifdef INREG_DOUBLE_BUF_EN
        FULL_PEND: begin
          if (release_rd) begin
            snap <= pend_data;
            if (in_valid) begin
              pend_data <= in_data;
              in_ready  <= 1'b0;
            end else begin
              state    <= FULL;
              in_ready <= 1'b1;
            end
          end else begin
            in_ready <= 1'b0;
          end
        end
`endif
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inreg.sv
// Scoreboard bench for inreg: a word-queue reference model predicts q and in_ready.
// Honours INREG_DOUBLE_BUF_EN by widening the model's holding capacity to two words.
module tb_inreg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic        rd;
  logic [3:0]  q;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;

`ifdef INREG_DOUBLE_BUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  always #5 clk = ~clk;

  inreg dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .rd       (rd),
    .q        (q),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready)
  );

  // Reference model: words held by the block, oldest first; front is the visible snapshot.
  logic [63:0] held[$];
  logic [63:0] last_word;
  int          drops;
  bit          m_ovf;

  logic [3:0]  exp_q[$];
  bit          exp_rdy[$];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [63:0] cur_snap();
    return (held.size() > 0) ? held[0] : last_word;
  endfunction

  function automatic logic [3:0] read_model(input logic [15:0] a);
    logic [63:0] s;
    int          k;
    if (a == 16'd6)
      return {1'b0, held.size() == 2, m_ovf, held.size() > 0};
    if (a == 16'd7)
      return 4'(drops);
    if (a >= 16'd10 && a <= 16'd70 && ((int'(a) - 10) % 4) == 0) begin
      k = (int'(a) - 10) / 4;
      s = cur_snap() >> (4 * k);
      return s[3:0];
    end
    return 4'h0;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model and queue what the DUT must show after the edge.
  task automatic applyStimulus(input bit r, input bit rdv, input logic [15:0] a,
                               input bit v, input logic [63:0] d);
    rst_n = r; rd = rdv; addr = a; in_valid = v; in_data = d;
    if (!r) begin
      held.delete();
      last_word = 64'h0;
      drops = 0;
      m_ovf = 1'b0;
      exp_q.push_back(4'h0);
      exp_rdy.push_back(1'b0);
    end else begin
      if (rdv)
        exp_q.push_back(read_model(a));
      if (rdv && a == 16'd70 && held.size() > 0)
        last_word = held.pop_front();
      if (rdv && a == 16'd7) begin
        drops = 0;
        m_ovf = 1'b0;
      end
      if (v) begin
        if (held.size() < CAP)
          held.push_back(d);
        else begin
          if (drops < 15)
            drops++;
          m_ovf = 1'b1;
        end
      end
      exp_rdy.push_back(held.size() < CAP);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic rd_at(input logic [15:0] a);
    applyStimulus(1'b1, 1'b1, a, 1'b0, 64'h0);
  endtask

  task automatic send(input logic [63:0] d);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, d);
  endtask

  // Monitor: sample strobes at the edge, compare outputs 1 time unit later.
  initial begin
    bit          rs;
    bit          rds;
    logic [15:0] as;
    forever begin
      @(posedge clk);
      rs = rst_n;
      rds = rd;
      as = addr;
      #1;
      if (!rs || rds) begin
        if (exp_q.size() == 0)
          checkOutput("q_queue_empty", 1, 0);
        else
          checkOutput($sformatf("q@%0d", as), int'(q), int'(exp_q.pop_front()));
      end
      if (exp_rdy.size() == 0)
        checkOutput("rdy_queue_empty", 1, 0);
      else
        checkOutput("in_ready", int'(in_ready), int'(exp_rdy.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation exceeded time bound");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [15:0] ra;
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 64'h0);
    rd_at(16'd6);
    rd_at(16'd40);

    send(64'h0123_4567_89AB_CDEF);
    rd_at(16'd6);
    for (int k = 0; k < 16; k++)
      rd_at(16'(10 + 4 * k));
    rd_at(16'd6);

    send(64'hDEAD_BEEF_CAFE_F00D);
    for (int i = 0; i < 17; i++)
      send({$urandom, $urandom});
    rd_at(16'd6);
    rd_at(16'd7);
    rd_at(16'd7);
    for (int k = 0; k < 16; k++)
      rd_at(16'(10 + 4 * k));
    rd_at(16'd70);
    rd_at(16'd70);
    rd_at(16'd6);

    send(64'h1111_2222_3333_4444);
    applyStimulus(1'b1, 1'b1, 16'd70, 1'b1, 64'hFFFF_0000_FFFF_0000);
    rd_at(16'd6);
    rd_at(16'd7);
    rd_at(16'd10);
    rd_at(16'd70);
    rd_at(16'd70);

    send(64'h5555_6666_7777_8888);
    send(64'h1);
    send(64'h2);
    send(64'h3);
    applyStimulus(1'b1, 1'b1, 16'd7, 1'b1, 64'h4);
    rd_at(16'd7);
    rd_at(16'd6);
    send(64'h5);
    send(64'h6);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 64'h0);
    rd_at(16'd6);
    rd_at(16'd7);

    send(64'hAAAA_AAAA_0000_0001);
    send(64'hBBBB_BBBB_0000_0002);
    rd_at(16'd6);
    send(64'hCCCC_CCCC_0000_0003);
    rd_at(16'd70);
    rd_at(16'd6);
    rd_at(16'd10);
    rd_at(16'd7);

    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 5))
        0: ra = 16'd6;
        1: ra = 16'd7;
        2, 3: ra = 16'd70;
        4: ra = 16'(10 + 4 * $urandom_range(0, 15));
        default: ra = 16'($urandom);
      endcase
      applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1, ra,
                    $urandom_range(0, 9) < 4, {$urandom, $urandom});
    end

    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inreg.md
# inreg

Memory-mapped 64-bit input capture register: the read-side counterpart of the CPU's nibble-addressed output register. It accepts a 64-bit word from an external producer over a valid/ready handshake, holds it as a stable snapshot, and serves it to the 4-bit CPU data bus one nibble per read. A status nibble and a saturating drop counter let software poll for new data and detect overruns.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst_n`  in  1  reset; one clock, synchronous and active-low (fixed)
- `addr`  in  16  CPU address
- `rd`  in  1  CPU read strobe, one cycle per access
- `q`  out  4  read data, registered
- `in_data`  in  64  producer word
- `in_valid`  in  1  producer word present this cycle
- `in_ready`  out  1  block can accept a word; registered, state-derived

## Operation
- Address map, decoded only when `rd`=1:
  - 6 = status `{2'b00, ovf, full}`
  - 7 = drop count
  - 10+4k, k=0..15 = snapshot bits [4k+3:4k]; 10→[3:0], 70→[63:60]
  - any other address → `q`=0
- `rd`=0: `q` holds its value.
- State machine (single-buffer build):
  - EMPTY: `in_ready`=1. On `in_valid`, load `in_data` into the snapshot and go to FULL.
  - FULL: `in_ready`=0, `full`=1. A read of address 70 is the release read; it returns [63:60] and the block goes to EMPTY.
- Release and arrival in the same cycle (FULL, `rd` at 70, `in_valid`=1):
  - the new word loads and the block stays FULL;
  - this is not counted as a drop;
  - `q` returns the old [63:60].
- Drop: `in_valid`=1 in FULL with no release read that cycle.
  - The word is discarded; the snapshot is unchanged.
  - Drop counter increments, saturating at 15.
  - `ovf` sets.
- Reading address 7:
  - returns the count before this read;
  - clears the counter and `ovf` at the same edge;
  - a drop in that same cycle makes the counter 1 and keeps `ovf`=1.
- Release does not clear the snapshot. Nibble reads in EMPTY return the last word (0 after reset).
- Status `full` in EMPTY = 0.

## Timing
- Read latency is 1 cycle: `rd`/`addr` sampled at edge N, `q` valid after edge N.
- Load: `in_valid` sampled at edge N. Snapshot and `full` update at N. `in_ready` falls after N.
- Release: `in_ready` rises after the release-read edge. The earliest next load is at the following edge, except for the same-cycle case above.
- Back-to-back reads are allowed every cycle.
- Reset, when `rst_n`=0 at an edge:
  - `q`=0, `in_ready`=0 during reset, snapshot=0, counter=0, `ovf`=0, state EMPTY;
  - `in_ready`=1 from the first edge with `rst_n`=1.
- Reset mid-operation discards any held or pending word; no drop is recorded.

## Configuration
- `INREG_DOUBLE_BUF_EN` defined: adds a 64-bit pending buffer and a third state, FULL_PEND.
  - FULL + `in_valid` → word goes to pending; next state FULL_PEND; `in_ready`=1 in FULL and 0 only in FULL_PEND.
  - Release in FULL_PEND: pending moves to the snapshot at that edge; next state FULL.
  - Drops occur only in FULL_PEND without a release. Release plus arrival in FULL_PEND: pending → snapshot, new word → pending, stay FULL_PEND.
  - Status bit 2 = `pend`.
- `INREG_DOUBLE_BUF_EN` undefined:
  - two-state single-buffer behaviour as above;
  - status bit 2 reads 0;
  - no pending register is synthesized.

## Test plan
- Reset then poll: after release of `rst_n`, read address 6 → `q`=4'h0, `in_ready`=1; read address 40 → `q`=4'h0.
- Capture and drain: send `in_data`=64'h0123_4567_89AB_CDEF.
  - Read address 6 → 4'h1.
  - Read 10, 14, …, 70 → F,E,D,C,B,A,9,8,7,6,5,4,3,2,1,0, each one cycle after its `rd`.
  - After the read of 70, `in_ready`=1 and status reads 4'h0.
- Overrun, single-buffer build: load a word, then pulse `in_valid` 17 times in FULL.
  - Status → 4'h3.
  - Read address 7 → 4'hF; next read of 7 → 4'h0.
  - Snapshot is still the first word.
- Same-cycle release and arrival: in FULL, assert `rd`@70 together with `in_valid` carrying 64'hFFFF_0000_FFFF_0000.
  - `q` = old [63:60].
  - Status stays 4'h1; drop count stays 0.
  - Read 10 → 4'h0; read 70 → 4'hF.
- Reset mid-operation: in FULL with 3 drops counted, hold `rst_n`=0 for one edge.
  - Status → 0, count → 0, `in_ready`=1 on the next cycle.
- With `INREG_DOUBLE_BUF_EN`: send two words A and B.
  - Status → 4'h5; `in_ready`=0.
  - Release read of 70 → status 4'h1; nibble reads return B.
  - A third word sent before the release is counted as a drop.
